uart_hex_receiver: RTL
======================

// Module: uart_hex_receiver
// PURPOSE
//  Serial-to-word receive path: samples an 8N1 UART line, decodes ASCII hex digits and
//  assembles them into a 32-bit word, delivered on a valid/ready handshake when CR or LF
//  arrives. Receive-side counterpart of the word-to-ASCII transmit path. Sits between the
//  board rxd pin and the debug register bank (memory-mapped read port).
// PARAMETERS
//  BIT_CYCLES  10417  clk cycles per UART bit (100 MHz / 9600 baud); must be >= 4
// PORTS
//  clk    in   1   system clock (clk100mhz); single clock domain
//  rstn   in   1   asynchronous, active-low reset
//  rxd    in   1   serial line, idle high, asynchronous to clk
//  rdy    in   1   consumer ready; word transfers on rdy & vld in the same cycle
//  dout   out  32  assembled word; stable while vld=1
//  vld    out  1   word available
//  err    out  1   one-cycle pulse: framing error or illegal character
//  ovf    out  1   one-cycle pulse: unconsumed word overwritten
//  busy   out  1   1 while bit FSM is outside IDLE
// BEHAVIOUR
//  Reset: dout=0, vld=0, err=0, ovf=0, busy=0; synchroniser flops=1; accumulator and digit
//   count=0; FSM=IDLE. Reset mid-frame aborts the frame; partial digits are discarded.
//  Input: 2-FF synchroniser on rxd; all decisions use the synchronised value rs.
//  Bit FSM (bit counter 0..BIT_CYCLES-1, bit index 0..7):
//   IDLE  : rs falling edge (1->0) -> START, counter cleared.
//   START : at counter=BIT_CYCLES/2-1 sample rs; 0 -> DATA (counter cleared);
//           1 -> false start, back to IDLE, no err.
//   DATA  : sample rs every BIT_CYCLES cycles (mid-bit); bit shifts in LSB first;
//           after bit 7 -> STOP.
//   STOP  : sample at mid-bit; 1 -> byte done, -> IDLE; 0 -> err pulse, byte dropped,
//           -> BREAK.
//   BREAK : stays until rs=1, then IDLE (no restart while line held low).
//  Byte decode (cycle after byte done):
//   '0'-'9','A'-'F','a'-'f': acc <= {acc[27:0],nib}; cnt <= min(cnt+1,8). More than 8
//     digits keeps the last 8.
//   0x0D or 0x0A: if cnt>0, dout<=acc, vld<=1 next cycle, acc<=0, cnt<=0; if cnt=0, ignored
//     (CR LF pair yields exactly one word).
//   0x20 (space): ignored, accumulator kept.
//   any other byte: err pulse, acc<=0, cnt<=0.
//  Handshake: vld stays 1 until cycle with rdy=1; vld falls the next cycle. rdy ignored
//   while vld=0. New word while vld=1 and no handshake: dout overwritten, vld stays 1,
//   ovf pulse. New word in same cycle as handshake: new word loaded, vld stays 1, no ovf.
//  Latency: vld rises 2 cycles after the stop-bit sample of the terminator.
//  err and ovf never assert together from one byte; both are single-cycle pulses.
// TESTING  (BIT_CYCLES=16 in bench)
//  send "1234ABCD\r", rdy=1 -> single vld pulse with dout=32'h1234ABCD, err=0
//  send "fF\n" with rdy=0 for 200 cycles, then rdy=1 -> dout=32'h000000FF held, vld drops
//    one cycle after handshake
//  send "123456789\r" -> dout=32'h23456789; then "\r" alone -> no vld
//  frame with stop bit 0 ('5', line low 3 bit-times) -> err 1 cycle, no digit stored,
//    FSM waits in BREAK until rxd high, next "7\r" -> dout=32'h00000007
//  "12G3\r" -> err at 'G', dout=32'h00000003; 4-cycle low glitch on idle rxd -> no byte
//  "A\r" then "B\r" with rdy=0 -> ovf pulse, dout=32'h0000000B; rstn low mid-byte ->
//    all outputs 0, next "C\r" -> dout=32'h0000000C

Source files
------------

// File: rtl/uart_hex_receiver.sv
// 8N1 UART receiver that decodes ASCII hex digits into a 32-bit word.
// CR or LF delivers the word on a vld/rdy handshake.
module uart_hex_receiver #(
  parameter int unsigned BIT_CYCLES = 10417
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxd,
  input  logic        rdy,
  output logic [31:0] dout,
  output logic        vld,
  output logic        err,
  output logic        ovf,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam logic [CntW-1:0] HalfLast = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rs_q, rs_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done_q, byte_done_d;
  logic            frame_err;
  logic [31:0]     acc_q, acc_d, dout_q, dout_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic            vld_q, vld_d, err_q, err_d, ovf_q, ovf_d, busy_q;
  logic            is_hex, load;
  logic [3:0]      nib;

  // Bit-level FSM: counter restarts at the start-bit midpoint so later samples land mid-bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    frame_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rs_prev_q && !rs_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = {rs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d = '0;
          if (rs_q) begin
            byte_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            frame_err = 1'b1;
            state_d   = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    is_hex = 1'b1;
    nib    = shift_q[3:0];
    if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
      nib = shift_q[3:0];
    end else if ((shift_q >= 8'h41 && shift_q <= 8'h46) ||
                 (shift_q >= 8'h61 && shift_q <= 8'h66)) begin
      nib = shift_q[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // Character decode runs the cycle after byte_done; shift_q is stable until the next frame.
  always_comb begin
    acc_d  = acc_q;
    dcnt_d = dcnt_q;
    load   = 1'b0;
    err_d  = frame_err;
    if (byte_done_q) begin
      if (is_hex) begin
        acc_d = {acc_q[27:0], nib};
        if (dcnt_q != 4'd8) dcnt_d = dcnt_q + 4'd1;
      end else if (shift_q == 8'h0D || shift_q == 8'h0A) begin
        if (dcnt_q != 4'd0) begin
          load   = 1'b1;
          acc_d  = '0;
          dcnt_d = '0;
        end
      end else if (shift_q != 8'h20) begin
        err_d  = 1'b1;
        acc_d  = '0;
        dcnt_d = '0;
      end
    end
    dout_d = dout_q;
    vld_d  = vld_q;
    ovf_d  = 1'b0;
    if (load) begin
      dout_d = acc_q;
      vld_d  = 1'b1;
      ovf_d  = vld_q && !rdy;
    end else if (vld_q && rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q   <= 1'b1;
      rs_q        <= 1'b1;
      rs_prev_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      acc_q       <= '0;
      dcnt_q      <= '0;
      dout_q      <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rs_q        <= rx_meta_q;
      rs_prev_q   <= rs_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      acc_q       <= acc_d;
      dcnt_q      <= dcnt_d;
      dout_q      <= dout_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign dout = dout_q;
  assign vld  = vld_q;
  assign err  = err_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;

endmodule
